// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the serial instruction-memory loader.
package imem_loader_pkg;

    // Loader sequencing states.
    typedef enum logic [2:0] {
        S_LEN_LO = 3'd0,
        S_LEN_HI = 3'd1,
        S_DATA   = 3'd2,
        S_WRITE  = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    // Header length in bytes (little-endian word count).
    localparam int HDR_BYTES  = 2;
    // Bytes per instruction word.
    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Shifts accepted bytes into a 32-bit little-endian word and flags the
// transfer that completes it.
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_next,
    output logic        word_full
);

    logic [1:0]  cnt_q;
    logic [1:0]  cnt_d;
    logic [31:0] word_q;
    logic [31:0] word_d;

    // Place the incoming byte at its lane and advance the byte count.
    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        if (clr) begin
            cnt_d = 2'd0;
        end else if (shift_en) begin
            word_d[{cnt_q, 3'b000} +: 8] = byte_in;
            cnt_d = cnt_q + 2'd1;
        end else begin
            cnt_d  = cnt_q;
            word_d = word_q;
        end
    end

    // The word including this byte is what gets written, so expose it directly.
    assign word_next = word_d;
    assign word_full = shift_en && !clr && (cnt_q == 2'(WORD_BYTES - 1));

    // Byte count and partial word registers; reset discards any partial word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q  <= 2'd0;
            word_q <= 32'd0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Serial program loader: parses a word count header followed by
// little-endian words, writes them to instruction memory and then releases
// the core from reset. A bad header parks the loader in an error state.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_rst,
    output logic        done,
    output logic        error
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int N_W   = 8 * HDR_BYTES;
    localparam logic [N_W:0] DEPTH_LIM = (N_W + 1)'(DEPTH_WORDS);

    state_t             state_q;
    state_t             state_d;
    logic [N_W-1:0]     n_q;
    logic [N_W-1:0]     n_d;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   idx_d;
    logic [31:0]        addr_q;
    logic [31:0]        addr_d;
    logic [31:0]        wdata_q;
    logic [31:0]        wdata_d;

    logic               accept;
    logic               xfer;
    logic               asm_clr;
    logic               asm_shift;
    logic [31:0]        asm_word;
    logic               asm_full;
    logic [N_W-1:0]     n_full;
    logic               hdr_bad;
    logic               last_word;

    assign accept     = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) || (state_q == S_DATA);
    assign byte_ready = rst && accept;
    assign xfer       = byte_valid && byte_ready;
    assign asm_shift  = xfer && (state_q == S_DATA);

    assign n_full    = {byte_data, n_q[7:0]};
    assign hdr_bad   = (n_full == N_W'(0)) || ({1'b0, n_full} > DEPTH_LIM);
    assign last_word = (N_W'(idx_q) == (n_q - N_W'(1)));

    word_assembler u_asm (
        .clk       (clk),
        .rst       (rst),
        .clr       (asm_clr),
        .shift_en  (asm_shift),
        .byte_in   (byte_data),
        .word_next (asm_word),
        .word_full (asm_full)
    );

    // Next-state, header capture and write-port staging.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        asm_clr = 1'b0;
        case (state_q)
            S_LEN_LO: begin
                if (xfer) begin
                    n_d     = {8'd0, byte_data};
                    state_d = S_LEN_HI;
                end else begin
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    n_d = n_full;
                    if (hdr_bad) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_LEN_HI;
                end
            end
            S_DATA: begin
                if (asm_full) begin
                    // Stage the write so address/data are valid with imem_we.
                    addr_d  = 32'({idx_q, 2'b00});
                    wdata_d = asm_word;
                    state_d = S_WRITE;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_WRITE: begin
                if (last_word) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    asm_clr = 1'b1;
                    state_d = S_DATA;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                // Unreachable encodings fall to the safe state: core held in reset.
                state_d = S_ERR;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_LEN_LO;
            n_q     <= '0;
            idx_q   <= '0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign imem_we    = (state_q == S_WRITE);
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign done       = (state_q == S_DONE);
    assign core_rst   = (state_q == S_DONE);
    assign error      = (state_q == S_ERR);

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter: DEPTH_WORDS, 256, instruction-memory capacity in 32-bit words.
REQ-002 SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: byte_valid  input  1  serial-side byte offered.
REQ-005 SHALL have port: byte_data  input  8  offered byte.
REQ-006 SHALL have port: byte_ready  output  1  loader accepts byte this cycle.
REQ-007 SHALL have port: imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-008 SHALL have port: imem_addr  output  32  word-aligned byte address of write.
REQ-009 SHALL have port: imem_wdata  output  32  instruction word to write.
REQ-010 SHALL have port: core_rst  output  1  active-low reset to the core; low while loading.
REQ-011 SHALL have port: done  output  1  program loaded, core released.
REQ-012 SHALL have port: error  output  1  illegal header; core stays in reset.

Function
REQ-013 SHALL transfer a byte only in a cycle with byte_valid=1 and byte_ready=1.
REQ-014 SHALL parse the stream as: 2-byte little-endian word count N, then N words of 4 bytes each, little-endian.
REQ-015 SHALL implement states LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR.
REQ-016 LEN_LO: byte_ready=1; on transfer capture N[7:0], go to LEN_HI.
REQ-017 LEN_HI: byte_ready=1; on transfer capture N[15:8]; if N==0 or N>DEPTH_WORDS go to ERR, else DATA.
REQ-018 DATA: byte_ready=1; transferred byte k (k=0..3) lands in wdata[8k+7:8k]; after k=3 go to WRITE.
REQ-019 WRITE: byte_ready=0, imem_we=1 for exactly one cycle, imem_addr=word_idx*4, imem_wdata=assembled word.
REQ-020 WRITE: if word_idx==N-1 go to DONE, else increment word_idx, clear byte count, go to DATA.
REQ-021 Per-word cost SHALL be 4 accepted bytes plus 1 write cycle; no throughput stall otherwise.
REQ-022 DONE: core_rst=1, done=1, byte_ready=0, imem_we=0; terminal until rst.
REQ-023 ERR: error=1, core_rst=0, byte_ready=0, imem_we=0; terminal until rst.
REQ-024 imem_addr/imem_wdata SHALL be don't-care but stable (hold last value) when imem_we=0.
REQ-025 byte_valid gaps in any byte position SHALL not corrupt assembly; count advances only on transfer.
REQ-026 word_idx SHALL never exceed DEPTH_WORDS-1 (guaranteed by REQ-017 check).

Reset
REQ-027 On rst=0 at a clock edge: state=LEN_LO, N=0, word_idx=0, byte count=0, wdata=0.
REQ-028 Reset values: byte_ready=0 during reset cycle, imem_we=0, imem_addr=0, imem_wdata=0, core_rst=0, done=0, error=0.
REQ-029 Reset mid-load SHALL abort with no further imem_we and restart header parsing; partial words discarded.

Structure
REQ-030 Package imem_loader_pkg SHALL hold the state enum and constants HDR_BYTES=2, WORD_BYTES=4.
REQ-031 One sub-module word_assembler (byte shift-in, 2-bit count, word_full flag) SHALL be instantiated.

Verification
REQ-032 Bytes 02 00 13 00 00 00 93 00 10 00 -> writes addr 0x0 data 0x00000013, addr 0x4 data 0x00100093; done=1, core_rst=1.
REQ-033 Header 00 00 -> error=1 one cycle after second byte; no imem_we; byte_ready=0.
REQ-034 DEPTH_WORDS=256, header 01 01 (N=257) -> error=1; header 00 01 (N=256) -> accepted, 256 writes, last addr 0x3FC.
REQ-035 N=1, byte_valid toggling 1/0 each cycle -> single write data matches bytes; byte_ready=0 exactly in WRITE cycle.
REQ-036 rst=0 asserted after 6 data bytes of N=2, then clean stream N=1 -> only one write at addr 0x0 with new data.
REQ-037 After done=1, further byte_valid=1 -> byte_ready stays 0, no imem_we, outputs unchanged.
